// File: rtl/keccak_padder_multi.sv
// Multi-mode Keccak padder: packs IN_W-bit message words into rate-sized blocks
// and applies SHA3 (0x06) / SHAKE (0x1F) domain separation plus the final 0x80 bit.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no message in progress; mode is sampled on the next word
// ABSORB | collecting words of the current block into slot cnt
// HOLD   | block complete, out valid and stable until f_ack
module keccak_padder_multi #(
    parameter int IN_W     = 32,
    parameter int MAX_RATE = 1344
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_W-1:0]               in,
    input  logic                          in_ready,
    input  logic                          is_last,
    input  logic [$clog2(IN_W/8)-1:0]     byte_num,
    input  logic [1:0]                    mode,
    input  logic                          f_ack,
    output logic                          buffer_full,
    output logic [MAX_RATE-1:0]           out,
    output logic                          out_ready,
    output logic                          out_last
);

    localparam int BYTES     = IN_W / 8;
    localparam int BN_W      = $clog2(BYTES);
    localparam int MAX_WORDS = MAX_RATE / IN_W;
    localparam int CNT_W     = $clog2(MAX_WORDS);
    localparam int IDX_W     = $clog2(MAX_RATE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MAX_RATE-1:0]   blk_q, blk_d;
    logic [1:0]            mode_q, mode_d;
    logic                  last_q, last_d;

    logic [1:0]            mode_eff;
    logic [IDX_W-1:0]      rate_m1;
    logic [CNT_W-1:0]      words_m1;
    logic [7:0]            ds;
    logic [IN_W-1:0]       word_val;
    logic [IDX_W-1:0]      word_base;

    // The first word of a message uses the live mode input; later words the latched one.
    always_comb begin
        mode_eff = (state_q == IDLE) ? mode : mode_q;
        rate_m1  = IDX_W'(1087);
        words_m1 = CNT_W'(1088 / IN_W - 1);
        ds       = 8'h06;
        case (mode_eff)
            2'd0: begin
                rate_m1  = IDX_W'(1087);
                words_m1 = CNT_W'(1088 / IN_W - 1);
                ds       = 8'h06;
            end
            2'd1: begin
                rate_m1  = IDX_W'(575);
                words_m1 = CNT_W'(576 / IN_W - 1);
                ds       = 8'h06;
            end
            2'd2: begin
                rate_m1  = IDX_W'(1343);
                words_m1 = CNT_W'(1344 / IN_W - 1);
                ds       = 8'h1F;
            end
            default: begin
                rate_m1  = IDX_W'(1087);
                words_m1 = CNT_W'(1088 / IN_W - 1);
                ds       = 8'h1F;
            end
        endcase
    end

    always_comb begin
        word_val = in;
        if (is_last) begin
            for (int k = 0; k < BYTES; k++) begin
                if (BN_W'(k) == byte_num)
                    word_val[k*8 +: 8] = ds;
                else if (BN_W'(k) > byte_num)
                    word_val[k*8 +: 8] = 8'h00;
            end
        end
    end

    assign word_base = IDX_W'(cnt_q) * IDX_W'(IN_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        mode_d  = mode_q;
        last_d  = last_q;
        case (state_q)
            IDLE, ABSORB: begin
                if (in_ready) begin
                    blk_d[word_base +: IN_W] = word_val;
                    if (state_q == IDLE)
                        mode_d = mode;
                    if (is_last) begin
                        // Slots past this word are already zero, so only the 0x80 bit remains.
                        blk_d[rate_m1] = 1'b1;
                        last_d  = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == words_m1) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = ABSORB;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (f_ack) begin
                    blk_d   = '0;
                    last_d  = 1'b0;
                    state_d = last_q ? IDLE : ABSORB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            blk_q  <= '0;
            mode_q <= 2'd0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            blk_q  <= blk_d;
            mode_q <= mode_d;
            last_q <= last_d;
        end
    end

    assign out         = blk_q;
    assign out_ready   = (state_q == HOLD);
    assign buffer_full = (state_q == HOLD);
    assign out_last    = last_q;

endmodule

// File: doc/keccak_padder_multi.md
# keccak_padder_multi

Parametrised multi-mode Keccak padder for the Kyber hash path. It accepts a message as a stream of IN_W-bit words, assembles rate-sized blocks, and applies SHA3 (0x06) or SHAKE (0x1F) domain-separation padding with the final 0x80 bit. Each block is handed to the Keccak-f permutation with an out_ready / f_ack handshake. It succeeds the fixed 32-bit / 576-bit SHA3-512 padder and adds run-time selection of all four Kyber hash modes.

## Interface
- IN_W, 32: input word width in bits; legal values are 32 and 64.
- MAX_RATE, 1344: output block width in bits; this is the largest supported rate.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- in  in  IN_W  message word; byte k is in[8k+7:8k] (little-endian).
- in_ready  in  1  `in` is valid this cycle.
- is_last  in  1  this word is the final, partial word of the message.
- byte_num  in  log2(IN_W/8)  number of valid message bytes in an is_last word (0..IN_W/8-1).
- mode  in  2  hash mode: 0 = SHA3-256 (rate 1088, ds 0x06), 1 = SHA3-512 (576, 0x06), 2 = SHAKE128 (1344, 0x1F), 3 = SHAKE256 (1088, 0x1F).
- f_ack  in  1  the permutation has consumed `out`.
- buffer_full  out  1  block held; in_ready is ignored while this is high.
- out  out  MAX_RATE  assembled block; word j is at out[j*IN_W +: IN_W]; bits at and above the rate are 0.
- out_ready  out  1  `out` is valid.
- out_last  out  1  this is the final block of the message.

## Operation
- Words per block: W = rate/IN_W. For IN_W=32 this gives 34/18/42/34 by mode; for IN_W=64 it gives 17/9/21/17.
- Word counter cnt: 0..W-1.
- States:
  - IDLE: no message in progress.
  - ABSORB: collecting words of the current block.
  - HOLD: block complete, waiting for f_ack.
- `mode` is latched on the first accepted word in IDLE. Changes to `mode` are ignored until the machine returns to IDLE.
- Word accepted: in_ready=1 and state is not HOLD.
  - The word is written to slot cnt and cnt increments.
  - IDLE moves to ABSORB.
- Non-last word that fills slot W-1: go to HOLD with out_last=0 and cnt=0.
- is_last word:
  - The message bytes are bytes 0..byte_num-1.
  - Byte byte_num = ds.
  - Higher bytes of that word are 0, and all later slots up to the rate are 0.
  - Bit 7 of rate byte (rate/8-1) is ORed with 1.
  - If the is_last word sits in slot W-1 and byte_num = IN_W/8-1, the final byte is ds|0x80 (0x86 or 0x9F).
  - Go to HOLD with out_last=1.
- A message whose length is a multiple of IN_W/8 bytes ends with a separate is_last word with byte_num=0. If that word lands in slot 0, the result is a padding-only block.
- HOLD with f_ack=1:
  - Clear the buffer to 0.
  - Drop out_ready.
  - If out_last=1, go to IDLE and clear out_last; otherwise go to ABSORB.
- f_ack outside HOLD is ignored.
- byte_num is ignored when is_last=0.

## Timing
- Reset values: out=0, out_ready=0, buffer_full=0, out_last=0, cnt=0, state IDLE.
- Reset applies asynchronously at any point, including mid-message and mid-HOLD. The partial block is discarded.
- out_ready and buffer_full both equal (state==HOLD). They are registered and rise 1 cycle after the accepting edge of the completing word.
- Throughput: one word per cycle while in ABSORB.
- A full block costs W cycles plus the HOLD time. HOLD time is at least 1 cycle; f_ack can be sampled in the first HOLD cycle.
- f_ack and in_ready in the same HOLD cycle: the word is not accepted. The source must hold it, and it is accepted the next cycle at the earliest.
- `out` is stable throughout HOLD.

## Test plan
- Reset then mode=1, IN_W=32: a single is_last word with byte_num=0 (empty message).
  - Next cycle: out_ready=1, out_last=1, out[7:0]=0x06, out[575:568]=0x80.
  - All other bits are 0, including out[1343:576].
- mode=2, IN_W=32: 41 words of 0xA5A5A5A5, then is_last, byte_num=3, in=0x00112233.
  - out[1343:1312]=0x9F112233 (byte 3 = 0x9F).
  - The 41 preceding words are intact; out_last=1.
- mode=1: 18 full words, then is_last with byte_num=0.
  - First HOLD: out_last=0. After f_ack, the second block is out[7:0]=0x06, out[575:568]=0x80, out_last=1.
  - The machine returns to IDLE after the second f_ack.
- Backpressure: keep in_ready=1 with in=0xDEADBEEF through HOLD and assert f_ack on the third HOLD cycle.
  - buffer_full=1 for exactly 3 cycles.
  - No word is captured during HOLD; the word is written to slot 0 on the cycle after f_ack.
- Change mode from 1 to 2 after the 5th word of a mode-1 message.
  - The block still completes at 18 words, with 0x80 at byte 71.
  - The next message, starting in IDLE, uses mode 2.
- Pull reset low in ABSORB at cnt=7 and again in HOLD.
  - All outputs go to 0 asynchronously.
  - The next message starts at slot 0 with the new mode latched.
